control_seq: RTL

Microcoded control sequencer for the single-bus RV32I core; successor to the fixed-length fetch/execute controller. Fetches an instruction onto the shared tri-state bus, latches it, then issues a per-opcode, variable-length sequence of one-hot strobes to memory, PC, register file and ALU. It sits between the bus and all datapath blocks and is the only block that drives immediates onto the bus.

---
 rtl/control_seq.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/control_seq.sv
// Microcoded RV32I control sequencer: fetches onto the shared bus, latches ir,
// then plays a per-opcode strobe sequence. Optional trap: CONTROL_SEQ_TRAP_EN.
module control_seq #(
   parameter int XLEN   = 32,
   parameter int STEP_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   inout  wire [XLEN-1:0]  bus,
   input  logic            alu_zero,
   output logic            mem_load,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic            pc_rd,
   output logic            pc_wr,
   output logic            pc_inc,
   output logic            reg_rd,
   output logic            reg_wr,
   output logic [4:0]      reg_addr,
   output logic            alu_wr,
   output logic            alu_rd,
   output logic [3:0]      alu_op,
   output logic            illegal
);
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [STEP_W-1:0] S1   = STEP_W'(1);
   localparam logic [STEP_W-1:0] S2   = STEP_W'(2);
   localparam logic [STEP_W-1:0] S3   = STEP_W'(3);
   localparam logic [STEP_W-1:0] S4   = STEP_W'(4);
   localparam logic [STEP_W-1:0] S5   = STEP_W'(5);
   localparam logic [STEP_W-1:0] S6   = STEP_W'(6);
   localparam logic [STEP_W-1:0] S7   = STEP_W'(7);
   localparam logic [STEP_W-1:0] S8   = STEP_W'(8);
   localparam logic [STEP_W-1:0] HALT = '1;

   logic [STEP_W-1:0] step;
   logic [31:0]       ir;
   logic              imm_en;
   logic [31:0]       imm32;
   logic              bad;
   logic              halt_next;

   logic [6:0] opcode;
   logic [4:0] rd, rs1, rs2;
   logic [2:0] funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign funct3 = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign imm_i  = {{20{ir[31]}}, ir[31:20]};
   assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_u  = {ir[31:12], 12'b0};
   assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

   assign bus = imm_en ? XLEN'(signed'(imm32)) : 'z;

   always_comb begin
      mem_load = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      pc_rd = 1'b0; pc_wr = 1'b0; pc_inc = 1'b0;
      reg_rd = 1'b0; reg_wr = 1'b0; reg_addr = 5'd0;
      alu_wr = 1'b0; alu_rd = 1'b0; alu_op = 4'b0000;
      illegal = 1'b0; imm_en = 1'b0; imm32 = 32'd0; bad = 1'b0;
      if (step == S1) begin
         pc_rd = 1'b1; mem_load = 1'b1;
      end else if (step == S2) begin
         mem_rd = 1'b1;
      end else if (step == HALT) begin
`ifdef CONTROL_SEQ_TRAP_EN
         illegal = 1'b1;
`endif
      end else if (step >= S3) begin
         case (opcode)
            OPC_OPIMM, OPC_OP: begin
               case (step)
                  S3: begin
                     alu_wr = 1'b1;
                     if (opcode == OPC_OPIMM) begin
                        imm_en = 1'b1; imm32 = imm_i;
                     end else begin
                        reg_rd = 1'b1; reg_addr = rs2;
                     end
                  end
                  S4: begin
                     reg_rd = 1'b1; reg_addr = rs1; alu_wr = 1'b1;
                     if (opcode == OPC_OP && funct3 == 3'b000 && ir[30]) alu_op = 4'b0001;
                     else if (funct3 == 3'b101 && ir[30])                alu_op = 4'b0101;
                     else                                                 alu_op = {1'b1, funct3};
                  end
                  S5: begin alu_rd = 1'b1; reg_wr = 1'b1; reg_addr = rd; pc_inc = 1'b1; end
                  default: ;
               endcase
            end
            OPC_LUI: begin
               if (step == S3) begin
                  imm_en = 1'b1; imm32 = imm_u; reg_wr = 1'b1; reg_addr = rd; pc_inc = 1'b1;
               end
            end
            OPC_AUIPC: begin
               case (step)
                  S3: begin imm_en = 1'b1; imm32 = imm_u; alu_wr = 1'b1; end
                  S4: begin pc_rd = 1'b1; alu_wr = 1'b1; alu_op = 4'b1000; end
                  S5: begin alu_rd = 1'b1; reg_wr = 1'b1; reg_addr = rd; pc_inc = 1'b1; end
                  default: ;
               endcase
            end
            OPC_LOAD, OPC_STORE: begin
               if (funct3 != 3'b010) bad = 1'b1;
               else begin
                  case (step)
                     S3: begin
                        imm_en = 1'b1; alu_wr = 1'b1;
                        imm32 = (opcode == OPC_STORE) ? imm_s : imm_i;
                     end
                     S4: begin reg_rd = 1'b1; reg_addr = rs1; alu_wr = 1'b1; alu_op = 4'b1000; end
                     S5: begin alu_rd = 1'b1; mem_load = 1'b1; end
                     S6: begin
                        pc_inc = 1'b1;
                        if (opcode == OPC_LOAD) begin
                           mem_rd = 1'b1; reg_wr = 1'b1; reg_addr = rd;
                        end else begin
                           reg_rd = 1'b1; reg_addr = rs2; mem_wr = 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            OPC_BRANCH: begin
               if (funct3[2:1] != 2'b00) bad = 1'b1;
               else begin
                  case (step)
                     S3: begin reg_rd = 1'b1; reg_addr = rs2; alu_wr = 1'b1; end
                     S4: begin reg_rd = 1'b1; reg_addr = rs1; alu_wr = 1'b1; alu_op = 4'b0001; end
                     S5: begin
                        // taken when the equality result matches BEQ/BNE polarity
                        if (alu_zero ^ funct3[0]) begin
                           imm_en = 1'b1; imm32 = imm_b; alu_wr = 1'b1;
                        end else begin
                           pc_inc = 1'b1;
                        end
                     end
                     S6: begin pc_rd = 1'b1; alu_wr = 1'b1; alu_op = 4'b1000; end
                     S7: begin alu_rd = 1'b1; pc_wr = 1'b1; end
                     default: ;
                  endcase
               end
            end
            OPC_JAL: begin
               case (step)
                  S3: begin pc_rd = 1'b1; alu_wr = 1'b1; end
                  S4: begin imm_en = 1'b1; imm32 = 32'd4; alu_wr = 1'b1; alu_op = 4'b1000; end
                  S5: begin alu_rd = 1'b1; reg_wr = 1'b1; reg_addr = rd; end
                  S6: begin imm_en = 1'b1; imm32 = imm_j; alu_wr = 1'b1; end
                  S7: begin pc_rd = 1'b1; alu_wr = 1'b1; alu_op = 4'b1000; end
                  S8: begin alu_rd = 1'b1; pc_wr = 1'b1; end
                  default: ;
               endcase
            end
            default: bad = 1'b1;
         endcase
         if (bad && step == S3) begin
`ifdef CONTROL_SEQ_TRAP_EN
            illegal = 1'b1;
`else
            pc_inc = 1'b1;
`endif
         end
      end
   end

`ifdef CONTROL_SEQ_TRAP_EN
   assign halt_next = illegal;
`else
   assign halt_next = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step <= '0;
         ir   <= 32'd0;
      end else begin
         if (step == S2) ir <= bus[31:0];
         if (pc_inc || pc_wr) step <= S1;
         else if (halt_next)  step <= HALT;
         else                 step <= step + 1'b1;
      end
   end
endmodule
